strategy1_accum: RTL and testbench
==================================

STRATEGY1_ACCUM -- requirements
Module: strategy1_accum

Interface
REQ-001 The block SHALL have parameter N_LANE, default 16, the number of lanes (one per strategy-1 adder output).
REQ-002 The block SHALL have parameter IN_W, default 23, the signed width of each lane input.
REQ-003 The block SHALL have parameter ACC_W, default 32, the signed width of each lane accumulator.
REQ-004 The block SHALL have parameter MAX_PLANES, default 8, the maximum number of bit-planes per accumulation.
REQ-005 i_clk  in  1  clock; all state SHALL change on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_valid  in  1  input plane present.
REQ-008 o_in_ready  out  1  block accepts a plane; a transfer occurs when i_valid and o_in_ready are both 1.
REQ-009 i_first  in  1  the plane is the first (MSB) plane of a group.
REQ-010 i_last  in  1  the plane is the final plane of a group.
REQ-011 i_neg  in  1  the plane is subtracted instead of added (signed-weight MSB plane).
REQ-012 i_result  in  N_LANE*IN_W  packed signed lane sums, lane k at [k*IN_W +: IN_W].
REQ-013 o_valid  out  1  accumulated group available.
REQ-014 i_ready  in  1  consumer accepts the group.
REQ-015 o_acc  out  N_LANE*ACC_W  packed signed lane accumulators, lane k at [k*ACC_W +: ACC_W].
REQ-016 o_err  out  1  sticky plane-overrun flag.

Function
REQ-017 The state machine SHALL have the states IDLE, ACCUM and DONE.
REQ-018 o_in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-019 Each transfer SHALL sign-extend the lane term x to ACC_W bits; term = i_neg ? -x : x.
REQ-020 A transfer with i_first=1 SHALL load acc = term in every lane and set the plane count to 1, from IDLE or ACCUM; a restart from ACCUM discards the partial result.
REQ-021 A transfer with i_first=0 in ACCUM SHALL update acc = (acc <<< 1) + term and increment the plane count.
REQ-022 A transfer with i_first=0 in IDLE SHALL be accepted and discarded, with no state change.
REQ-023 A transfer with i_last=1 SHALL move the block to DONE; i_first=i_last=1 gives a single-plane group.
REQ-024 A transfer with i_first=1 and i_last=0 SHALL move the block to ACCUM.
REQ-025 Latency: o_valid SHALL be 1 in the cycle after the last-plane transfer, with o_acc final.
REQ-026 In DONE, o_valid=1 and o_acc SHALL hold stable until i_ready=1; the block then returns to IDLE on the next edge.
REQ-027 Overrun: a transfer in ACCUM with plane count = MAX_PLANES-1 and i_last=0 SHALL be treated as last, go to DONE and set o_err=1.
REQ-028 o_err SHALL stay 1 until reset.

Reset
REQ-029 Asserting i_rst_n low SHALL set the state to IDLE, o_valid=0, o_acc=0, o_err=0 and the plane count to 0, even mid-group or while o_valid=1.
REQ-030 After reset, o_in_ready SHALL be 1.

Configuration
REQ-031 With STRATEGY1_ACCUM_SAT_EN defined, each lane update SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1], covering both the shift and the add.
REQ-032 Without STRATEGY1_ACCUM_SAT_EN, each lane update SHALL wrap modulo 2^ACC_W.

Structure
REQ-033 The package strategy1_pkg SHALL hold the state enum, default N_LANE/IN_W/ACC_W/MAX_PLANES and the lane slice helper constants.
REQ-034 The per-lane shift-add (with optional saturation) SHALL be one sub-module, strategy1_accum_lane, instantiated N_LANE times; control SHALL be a single FSM in strategy1_accum.

Verification
REQ-035 Scenario, 3-plane group: lane0 planes 5 (first), 3, -2 (last), all i_neg=0 -> o_acc lane0 = ((5*2)+3)*2-2 = 24, o_valid one cycle after the last plane.
REQ-036 Scenario, signed MSB plane: first plane x=1 with i_neg=1, then x=1, then x=0 (last) -> lane = ((-1*2)+1)*2+0 = -2.
REQ-037 Scenario, backpressure: i_ready=0 for 5 cycles in DONE -> o_valid stays 1, o_acc stable, o_in_ready=0; i_ready=1 -> IDLE on the next edge.
REQ-038 Scenario, restart and stray input: i_first mid-group discards the partial sum (new result = new planes only); i_valid with i_first=0 in IDLE -> no state change, o_valid stays 0.
REQ-039 Scenario, overrun: 8 planes with no i_last -> DONE after the 8th plane, o_err=1, o_err still 1 after the group drains.
REQ-040 Scenario, saturation and reset: accumulate 0x3FFFFF over 8 planes -> o_acc clamps to 2^31-1 with STRATEGY1_ACCUM_SAT_EN and wraps without it; i_rst_n low mid-ACCUM -> all outputs 0 and IDLE.

Source files
------------

// File: rtl/strategy1_pkg.sv
// strategy1_pkg
//   Shared definitions for the strategy-1 bit-plane accumulator:
//   - state_e        : control FSM states (IDLE, ACCUM, DONE)
//   - DEF_*          : default lane count, lane input width, accumulator width
//                      and maximum bit-planes per group
//   - lane_lo()      : LSB position of lane k in a packed lane bus
package strategy1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_N_LANE     = 16;
  localparam int unsigned DEF_IN_W       = 23;
  localparam int unsigned DEF_ACC_W      = 32;
  localparam int unsigned DEF_MAX_PLANES = 8;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/strategy1_accum_lane.sv
// strategy1_accum_lane
//   One lane of the bit-plane accumulator: acc = term on load, or
//   acc = (acc <<< 1) + term on update, where term = i_neg ? -x : x with x
//   sign-extended. Wraps modulo 2^ACC_W by default; with STRATEGY1_ACCUM_SAT_EN
//   defined, the combined shift-and-add saturates to the ACC_W signed range.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (acc cleared)
//   i_load         : load acc with the term (first plane)
//   i_upd          : shift-and-add the term (subsequent plane)
//   i_neg          : subtract the term instead of adding it
//   i_x [IN_W]     : signed lane input
//   o_acc [ACC_W]  : signed lane accumulator
module strategy1_accum_lane #(
  parameter int unsigned IN_W  = 23,
  parameter int unsigned ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_upd,
  input  logic             i_neg,
  input  logic [IN_W-1:0]  i_x,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

`ifdef STRATEGY1_ACCUM_SAT_EN
  // Two guard bits hold the exact value of 2*acc + term before clamping.
  localparam int unsigned W_W = ACC_W + 2;
  localparam logic signed [W_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [W_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [W_W-1:0] x_w, term_w, acc_w2, sum_w;

  always_comb begin
    x_w    = {{(W_W-IN_W){i_x[IN_W-1]}}, i_x};
    term_w = i_neg ? -x_w : x_w;
    acc_w2 = {acc_q[ACC_W-1], acc_q, 1'b0};
    sum_w  = i_load ? term_w : acc_w2 + term_w;
    acc_d  = acc_q;
    if (i_load || i_upd) begin
      if (sum_w > SAT_MAX) begin
        acc_d = {1'b0, {(ACC_W-1){1'b1}}};
      end else if (sum_w < SAT_MIN) begin
        acc_d = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end
`else
  logic signed [ACC_W-1:0] x_a, term_a, sum_a;

  always_comb begin
    x_a    = {{(ACC_W-IN_W){i_x[IN_W-1]}}, i_x};
    term_a = i_neg ? -x_a : x_a;
    sum_a  = i_load ? term_a : (acc_q <<< 1) + term_a;
    acc_d  = acc_q;
    if (i_load || i_upd) begin
      acc_d = sum_a;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/strategy1_accum.sv
// strategy1_accum
//   Accumulates groups of bit-planes (MSB first) across N_LANE lanes.
//   Optional feature macro: STRATEGY1_ACCUM_SAT_EN (saturating lane updates;
//   default build wraps modulo 2^ACC_W).
// Ports:
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_valid, o_in_ready : plane handshake (transfer when both are 1)
//   i_first, i_last     : plane is first / last of its group
//   i_neg               : plane is subtracted (signed-weight MSB plane)
//   i_result            : packed signed lane inputs, lane k at [k*IN_W +: IN_W]
//   o_valid, i_ready    : result handshake; o_acc held while o_valid && !i_ready
//   o_acc               : packed signed accumulators, lane k at [k*ACC_W +: ACC_W]
//   o_err               : sticky plane-overrun flag
module strategy1_accum
  import strategy1_pkg::*;
#(
  parameter int unsigned N_LANE     = DEF_N_LANE,
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned MAX_PLANES = DEF_MAX_PLANES
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_in_ready,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    i_neg,
  input  logic [N_LANE*IN_W-1:0]  i_result,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [N_LANE*ACC_W-1:0] o_acc,
  output logic                    o_err
);

  localparam int unsigned CNT_W = $clog2(MAX_PLANES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             xfer, lane_load, lane_upd;

  assign o_in_ready = (state_q != ST_DONE);
  assign xfer       = i_valid && o_in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    lane_load = 1'b0;
    lane_upd  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (xfer) begin
          if (i_first) begin
            lane_load = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = i_last ? ST_DONE : ST_ACCUM;
          end else if (state_q == ST_ACCUM) begin
            // Non-first planes in IDLE are accepted and dropped.
            lane_upd = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (i_last) begin
              state_d = ST_DONE;
            end else if (cnt_q == CNT_W'(MAX_PLANES - 1)) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_err   = err_q;

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    strategy1_accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (lane_load),
      .i_upd   (lane_upd),
      .i_neg   (i_neg),
      .i_x     (i_result[lane_lo(k, IN_W) +: IN_W]),
      .o_acc   (o_acc[lane_lo(k, ACC_W) +: ACC_W])
    );
  end

endmodule

// File: tb/tb_strategy1_accum.sv
// tb_strategy1_accum
//   Random and directed planes against a behavioural group-accumulation model.
//   ACC_W is narrowed to 28 so that 8-plane groups of large inputs reach the
//   accumulator range limits. STRATEGY1_ACCUM_SAT_EN selects the saturating
//   expectations.
module tb_strategy1_accum;

  localparam int unsigned P_N_LANE = 16;
  localparam int unsigned P_IN_W   = 23;
  localparam int unsigned P_ACC_W  = 28;
  localparam int unsigned P_MAX    = 8;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        i_valid = 1'b0;
  logic                        o_in_ready;
  logic                        i_first = 1'b0;
  logic                        i_last = 1'b0;
  logic                        i_neg = 1'b0;
  logic [P_N_LANE*P_IN_W-1:0]  i_result = '0;
  logic                        o_valid;
  logic                        i_ready = 1'b0;
  logic [P_N_LANE*P_ACC_W-1:0] o_acc;
  logic                        o_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  strategy1_accum #(
    .N_LANE     (P_N_LANE),
    .IN_W       (P_IN_W),
    .ACC_W      (P_ACC_W),
    .MAX_PLANES (P_MAX)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_first    (i_first),
    .i_last     (i_last),
    .i_neg      (i_neg),
    .i_result   (i_result),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_acc      (o_acc),
    .o_err      (o_err)
  );

  // ---------------- behavioural model ----------------
  longint m_acc [P_N_LANE];
  bit     m_busy = 1'b0;   // a group is being collected
  bit     m_hold = 1'b0;   // a finished group is being offered
  bit     m_err  = 1'b0;
  int     m_planes = 0;

  initial foreach (m_acc[k]) m_acc[k] = 0;

  function automatic longint fit(longint v);
    longint hi, lo, r;
    hi = (longint'(1) <<< (P_ACC_W - 1)) - 1;
    lo = -(longint'(1) <<< (P_ACC_W - 1));
`ifdef STRATEGY1_ACCUM_SAT_EN
    r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    r = v & ((longint'(1) <<< P_ACC_W) - 1);
    if (r > hi) r = r - (longint'(1) <<< P_ACC_W);
`endif
    return r;
  endfunction

  function automatic longint lane_term(int k);
    logic signed [P_IN_W-1:0] x;
    longint t;
    x = i_result[k*P_IN_W +: P_IN_W];
    t = longint'(x);
    return i_neg ? -t : t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_acc[k]) m_acc[k] = 0;
      m_busy = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_planes = 0;
    end else if (m_hold) begin
      if (i_ready) m_hold = 1'b0;
    end else if (i_valid) begin
      if (i_first) begin
        foreach (m_acc[k]) m_acc[k] = fit(lane_term(k));
        m_planes = 1;
        m_hold   = i_last;
        m_busy   = !i_last;
      end else if (m_busy) begin
        foreach (m_acc[k]) m_acc[k] = fit(2 * m_acc[k] + lane_term(k));
        m_planes++;
        if (i_last || m_planes == P_MAX) begin
          if (!i_last) m_err = 1'b1;
          m_hold = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  function automatic logic [P_N_LANE*P_ACC_W-1:0] model_vec();
    logic [P_N_LANE*P_ACC_W-1:0] e;
    logic [P_ACC_W-1:0]          s;
    e = '0;
    for (int k = 0; k < P_N_LANE; k++) begin
      s = P_ACC_W'(m_acc[k]);
      e[k*P_ACC_W +: P_ACC_W] = s;
    end
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk1(string name, longint got, longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkv(string name, logic [P_N_LANE*P_ACC_W-1:0] got,
                      logic [P_N_LANE*P_ACC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic longint acc_lane(int k);
    logic signed [P_ACC_W-1:0] s;
    s = o_acc[k*P_ACC_W +: P_ACC_W];
    return longint'(s);
  endfunction

  function automatic logic [P_N_LANE*P_IN_W-1:0] vec0(longint x);
    logic [P_N_LANE*P_IN_W-1:0] v;
    v = '0;
    v[P_IN_W-1:0] = P_IN_W'(x);
    return v;
  endfunction

  function automatic logic [P_N_LANE*P_ACC_W-1:0] accvec0(longint x);
    logic [P_N_LANE*P_ACC_W-1:0] v;
    v = '0;
    v[P_ACC_W-1:0] = P_ACC_W'(x);
    return v;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_valid", o_valid, 0);
      chk1("rst_err", o_err, 0);
      chk1("rst_in_ready", o_in_ready, 1);
      chkv("rst_acc", o_acc, '0);
    end else begin
      chk1("in_ready", o_in_ready, !m_hold);
      chk1("valid", o_valid, m_hold);
      chk1("err", o_err, m_err);
      if (m_hold) chkv("acc", o_acc, model_vec());
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(bit f, bit l, bit n, logic [P_N_LANE*P_IN_W-1:0] v);
    int w;
    i_first = f; i_last = l; i_neg = n; i_result = v; i_valid = 1'b1;
    w = 0;
    while (!o_in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk1("send_timeout", w, 0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_neg = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P_N_LANE*P_IN_W-1:0] v;
    logic [P_IN_W-1:0]          x;

    repeat (3) @(posedge clk);
    #1;
    chk1("reset_in_ready", o_in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-plane group: ((5*2)+3)*2-2 = 24, valid right after last plane.
    send(1, 0, 0, vec0(5));
    send(0, 0, 0, vec0(3));
    send(0, 1, 0, vec0(-2));
    chk1("p3_valid_latency", o_valid, 1);
    chk1("p3_lane0", acc_lane(0), 24);

    // Backpressure: five cycles held, then release.
    repeat (5) begin
      @(posedge clk); #1;
      chk1("bp_valid", o_valid, 1);
      chk1("bp_in_ready", o_in_ready, 0);
      chkv("bp_stable", o_acc, accvec0(24));
    end
    drain();
    chk1("bp_release_valid", o_valid, 0);
    chk1("bp_release_in_ready", o_in_ready, 1);

    // Signed MSB plane: ((-1*2)+1)*2+0 = -2.
    send(1, 0, 1, vec0(1));
    send(0, 0, 0, vec0(1));
    send(0, 1, 0, vec0(0));
    chk1("neg_lane0", acc_lane(0), -2);
    drain();

    // Restart mid-group: only 2*2+1 = 5 survives.
    send(1, 0, 0, vec0(100));
    send(0, 0, 0, vec0(7));
    send(1, 0, 0, vec0(2));
    send(0, 1, 0, vec0(1));
    chk1("restart_lane0", acc_lane(0), 5);
    drain();

    // Stray plane in IDLE is swallowed.
    send(0, 0, 0, vec0(9));
    chk1("stray_valid", o_valid, 0);
    chk1("stray_in_ready", o_in_ready, 1);
    chk1("stray_err", o_err, 0);
    send(1, 1, 0, vec0(-7));
    chk1("single_valid", o_valid, 1);
    chk1("single_lane0", acc_lane(0), -7);
    drain();

    // Overrun: 8 planes of 1 without last -> 255, err set and sticky.
    send(1, 0, 0, vec0(1));
    repeat (6) send(0, 0, 0, vec0(1));
    chk1("ovr_not_yet", o_valid, 0);
    send(0, 0, 0, vec0(1));
    chk1("ovr_valid", o_valid, 1);
    chk1("ovr_err", o_err, 1);
    chk1("ovr_lane0", acc_lane(0), 255);
    drain();
    chk1("ovr_err_sticky", o_err, 1);
    chk1("ovr_drained", o_valid, 0);

    // Range limit: 0x3FFFFF * 255 exceeds the 28-bit accumulator.
    send(1, 0, 0, vec0(23'h3FFFFF));
    repeat (6) send(0, 0, 0, vec0(23'h3FFFFF));
    send(0, 1, 0, vec0(23'h3FFFFF));
`ifdef STRATEGY1_ACCUM_SAT_EN
    chk1("sat_lane0", acc_lane(0), 134217727);
`else
    chk1("wrap_lane0", acc_lane(0), -4194559);
`endif
    drain();

    // Reset mid-group clears everything, including the sticky error.
    send(1, 0, 0, vec0(3));
    send(0, 0, 0, vec0(3));
    chk1("pre_rst_valid", o_valid, 0);
    rst_n = 1'b0;
    #2;
    chk1("mid_rst_valid", o_valid, 0);
    chk1("mid_rst_err", o_err, 0);
    chk1("mid_rst_in_ready", o_in_ready, 1);
    chkv("mid_rst_acc", o_acc, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 1, 0, vec0(5));
    chk1("post_rst_stray_valid", o_valid, 0);

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      v = '0;
      for (int k = 0; k < P_N_LANE; k++) begin
        case ($urandom_range(0, 7))
          0:       x = 23'h3FFFFF;
          1:       x = 23'h400000;
          default: x = P_IN_W'($urandom);
        endcase
        v[k*P_IN_W +: P_IN_W] = x;
      end
      send($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, v);
    end
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
